// File: rtl/data_memory_if.sv
// data_memory_if: request/response bus between the load/store stage and data_memory
interface data_memory_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic req;
   logic we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W/8-1:0] be;
   logic ready;
   logic rvalid;
   logic [DATA_W-1:0] rdata;
   logic err;
   modport master (output req, we, addr, wdata, be, input ready, rvalid, rdata, err);
   modport slave (input req, we, addr, wdata, be, output ready, rvalid, rdata, err);
endinterface

// File: rtl/data_memory.sv
// data_memory: synchronous byte-enabled data memory with 1-cycle read; define MEM_INIT_EN to preload mem[i] = i after reset
module data_memory #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH = 32
) (
   input logic clk,
   input logic rst_n,
   data_memory_if.slave bus
);
   localparam int NB = DATA_W / 8;
   typedef enum logic {INIT, IDLE} state_t;
   state_t state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic acc;
   logic oor;
   assign acc = bus.req && bus.ready;
   assign oor = 32'(bus.addr) >= DEPTH;
`ifdef MEM_INIT_EN
   localparam int CW = $clog2(DEPTH + 1);
   logic [CW-1:0] cnt;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= INIT;
`ifdef MEM_INIT_EN
         cnt <= '0;
`endif
         bus.ready <= 1'b0;
         bus.rvalid <= 1'b0;
         bus.rdata <= '0;
         bus.err <= 1'b0;
      end else begin
         bus.rvalid <= acc && !bus.we;
         bus.err <= acc && oor;
         if (acc && !bus.we) bus.rdata <= oor ? '0 : mem[bus.addr];
         if (state == INIT) begin
`ifdef MEM_INIT_EN
            cnt <= cnt + 1'b1;
            if (cnt == CW'(DEPTH - 1)) begin
               state <= IDLE;
               bus.ready <= 1'b1;
            end
`else
            state <= IDLE;
            bus.ready <= 1'b1;
`endif
         end
      end
   // array has no reset; the init walk (when enabled) is its only initialisation
   always_ff @(posedge clk) begin
`ifdef MEM_INIT_EN
      if (state == INIT) mem[ADDR_W'(cnt)] <= DATA_W'(cnt);
`endif
      if (acc && bus.we && !oor)
         for (int k = 0; k < NB; k++)
            if (bus.be[k]) mem[bus.addr][8*k +: 8] <= bus.wdata[8*k +: 8];
   end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: scoreboard bench driving a DEPTH=32 and a DEPTH=20 instance with identical stimulus
module tb_data_memory;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic req = 1'b0;
   logic we = 1'b0;
   logic [4:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0] be = '0;
   always #5 clk = ~clk;
   data_memory_if #(.DATA_W(32), .ADDR_W(5)) b0 ();
   data_memory_if #(.DATA_W(32), .ADDR_W(5)) b1 ();
   assign b0.req = req;
   assign b0.we = we;
   assign b0.addr = addr;
   assign b0.wdata = wdata;
   assign b0.be = be;
   assign b1.req = req;
   assign b1.we = we;
   assign b1.addr = addr;
   assign b1.wdata = wdata;
   assign b1.be = be;
   data_memory #(.DATA_W(32), .ADDR_W(5), .DEPTH(32)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   data_memory #(.DATA_W(32), .ADDR_W(5), .DEPTH(20)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   typedef struct {
      bit rv;
      logic [31:0] rd;
      bit er;
      int st;
   } exp_t;
   exp_t q[2][$];
   logic [31:0] mm[2][32];
   logic [31:0] last[2];
   int depth[2] = '{32, 20};
`ifdef MEM_INIT_EN
   int lat[2] = '{32, 20};
`else
   int lat[2] = '{1, 1};
`endif
   int edges = 0;
   int nedge = 0;
   int pass = 0;
   int total = 0;
   logic rv_s[2], er_s[2], rdy_s[2];
   logic [31:0] rd_s[2];
   assign rv_s[0] = b0.rvalid;
   assign rv_s[1] = b1.rvalid;
   assign er_s[0] = b0.err;
   assign er_s[1] = b1.err;
   assign rdy_s[0] = b0.ready;
   assign rdy_s[1] = b1.ready;
   assign rd_s[0] = b0.rdata;
   assign rd_s[1] = b1.rdata;
   task automatic chk(string n, int d, logic [31:0] a, logic [31:0] e);
      total++;
      if (a !== e) $display("FAIL %s dut%0d t=%0t got=%h want=%h", n, d, $time, a, e);
      else pass++;
   endtask
   always @(negedge clk) begin
      exp_t e;
      nedge++;
      for (int d = 0; d < 2; d++) begin
         chk("ready", d, 32'(rdy_s[d]), 32'(edges >= lat[d]));
         if (rv_s[d] || er_s[d]) begin
            if (q[d].size() == 0) chk("spurious_pulse", d, {30'b0, rv_s[d], er_s[d]}, 32'h0);
            else begin
               e = q[d].pop_front();
               chk("latency", d, 32'(nedge), 32'(e.st));
               chk("rvalid", d, 32'(rv_s[d]), 32'(e.rv));
               chk("err", d, 32'(er_s[d]), 32'(e.er));
               if (e.rv) last[d] = e.rd;
            end
         end else if (q[d].size() > 0 && q[d][0].st <= nedge) begin
            e = q[d].pop_front();
            chk("missing_pulse", d, 32'h0, {30'b0, e.rv, e.er});
         end
         chk("rdata", d, rd_s[d], last[d]);
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
      if (rst_n) edges++;
   endtask
   task automatic model(int d, bit w, int a, logic [31:0] wd, logic [3:0] b);
      exp_t e;
      bit o;
      logic [31:0] m;
      o = a >= depth[d];
      m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
      e.st = nedge + 2;
      e.rv = !w;
      e.er = o;
      e.rd = (w || o) ? 32'h0 : mm[d][a];
      if (w && !o) mm[d][a] = (mm[d][a] & ~m) | (wd & m);
      if (!w || o) q[d].push_back(e);
   endtask
   task automatic issue(bit r, bit w, int a, logic [31:0] wd, logic [3:0] b);
      req = r;
      we = w;
      addr = a[4:0];
      wdata = wd;
      be = b;
      for (int d = 0; d < 2; d++)
         if (r && edges >= lat[d]) model(d, w, a, wd, b);
      step();
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         q[d].delete();
         last[d] = 32'h0;
      end
      chk("rst_out", 0, {b0.ready, b0.rvalid, b0.err, 29'b0} | b0.rdata, 32'h0);
      chk("rst_out", 1, {b1.ready, b1.rvalid, b1.err, 29'b0} | b1.rdata, 32'h0);
      edges = 0;
      repeat (2) step();
      rst_n = 1'b1;
`ifdef MEM_INIT_EN
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < depth[d]; i++) mm[d][i] = i;
`endif
   endtask
   task automatic fill();
`ifndef MEM_INIT_EN
      for (int a = 0; a < 32; a++) issue(1, 1, a, $urandom, 4'hf);
`endif
   endtask
   initial begin
      #1;
      do_reset();
      // requests during init must be ignored until each instance is ready
      while (edges < lat[0]) issue(1, 0, $urandom_range(0, 31), $urandom, 4'hf);
      fill();
      issue(1, 0, 0, 0, 0);
      issue(1, 0, 7, 0, 0);
      issue(1, 0, 31, 0, 0);
      issue(1, 1, 5, 32'hDEADBEEF, 4'b0101);
      issue(1, 0, 5, 0, 0);
      issue(1, 0, 1, 0, 0);
      issue(1, 0, 2, 0, 0);
      issue(1, 0, 3, 0, 0);
      issue(1, 0, 25, 0, 0);
      issue(1, 1, 25, 32'hFFFFFFFF, 4'hf);
      issue(1, 0, 19, 0, 0);
      issue(1, 1, 9, 32'h11223344, 4'h0);
      issue(1, 0, 9, 0, 0);
      issue(0, 0, 0, 0, 0);
      for (int i = 0; i < 400; i++)
         issue($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom, 4'($urandom_range(0, 15)));
      issue(1, 1, 3, 32'h1234, 4'hf);
      issue(1, 0, 3, 0, 0);
      do_reset();
      while (edges < lat[0]) issue(0, 0, 0, 0, 0);
      fill();
      issue(1, 0, 3, 0, 0);
      issue(1, 0, 19, 0, 0);
      repeat (3) issue(0, 0, 0, 0, 0);
      for (int d = 0; d < 2; d++) chk("queue_drained", d, 32'(q[d].size()), 32'h0);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
